// File: rtl/pio_pkg.sv
// Shared definitions for the hardware edge-capture PIO service master:
// slave register map and the sequencing state encoding.
package pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        IDLE   = 3'd1,
        RD_EC  = 3'd2,
        CLR    = 3'd3,
        RD_LVL = 3'd4,
        PUSH   = 3'd5
    } pio_state_e;

endpackage

// File: rtl/avm_single_xfer.sv
// Single-transfer Avalon-MM engine: registers one read or write command, holds it
// through waitrequest, and flags completion (write accept / first readdatavalid).
module avm_single_xfer #(
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_write,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              xfer_idle,
    output logic              xfer_done,
    output logic [DATA_W-1:0] xfer_rdata,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid
);

    logic [1:0]  avm_address_q, avm_address_d;
    logic        avm_read_q, avm_read_d;
    logic        avm_write_q, avm_write_d;
    logic [31:0] avm_writedata_q, avm_writedata_d;
    logic        pend_q, pend_d;
    logic        accept_s;
    logic        rdata_unused_s;

    assign accept_s       = (avm_read_q | avm_write_q) & ~avm_waitrequest;
    assign xfer_done      = (avm_write_q & ~avm_waitrequest) | (pend_q & avm_readdatavalid);
    assign xfer_idle      = ~avm_read_q & ~avm_write_q & ~pend_q;
    assign xfer_rdata     = avm_readdata[DATA_W-1:0];
    assign rdata_unused_s = ^avm_readdata;

    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;

    // Command hold/launch; a response with no read pending never sets or clears anything.
    always_comb begin
        avm_address_d   = avm_address_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_writedata_d = avm_writedata_q;
        pend_d          = pend_q & ~avm_readdatavalid;
        if (start) begin
            avm_read_d      = ~is_write;
            avm_write_d     = is_write;
            avm_address_d   = addr;
            avm_writedata_d = 32'd0;
            if (is_write) begin
                avm_writedata_d[DATA_W-1:0] = wdata;
            end else begin
                avm_writedata_d = 32'd0;
            end
        end else if (accept_s) begin
            pend_d      = avm_read_q;
            avm_read_d  = 1'b0;
            avm_write_d = 1'b0;
        end else begin
            pend_d = pend_q & ~avm_readdatavalid;
        end
    end

    // Command and outstanding-read registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address_q   <= 2'd0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_writedata_q <= 32'd0;
            pend_q          <= 1'b0;
        end else begin
            avm_address_q   <= avm_address_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_writedata_q <= avm_writedata_d;
            pend_q          <= pend_d;
        end
    end

endmodule

// File: rtl/pio_event_master.sv
// Services an edge-capturing PIO slave without a CPU: programs irq_mask, then per irq
// reads and clears edge_capture, reads the level and emits one valid/ready record.
module pio_event_master
    import pio_pkg::*;
#(
    parameter int                DATA_W    = 2,
    parameter logic [DATA_W-1:0] INIT_MASK = 2'b11,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    input  logic              pio_irq,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_edges,
    output logic [DATA_W-1:0] evt_level,
    output logic [CNT_W-1:0]  evt_count,
    output logic              busy
);

    pio_state_e        state_q, state_d;
    logic [DATA_W-1:0] ec_q, ec_d;
    logic              evt_valid_q, evt_valid_d;
    logic [DATA_W-1:0] evt_edges_q, evt_edges_d;
    logic [DATA_W-1:0] evt_level_q, evt_level_d;
    logic [CNT_W-1:0]  evt_count_q, evt_count_d;
    logic              busy_q, busy_d;

    logic              start_s, is_write_s;
    logic [1:0]        addr_s;
    logic [DATA_W-1:0] wdata_s;
    logic              xfer_idle_s, xfer_done_s;
    logic [DATA_W-1:0] xfer_rdata_s;

    avm_single_xfer #(.DATA_W(DATA_W)) u_xfer (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start_s),
        .is_write          (is_write_s),
        .addr              (addr_s),
        .wdata             (wdata_s),
        .xfer_idle         (xfer_idle_s),
        .xfer_done         (xfer_done_s),
        .xfer_rdata        (xfer_rdata_s),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_readdata      (avm_readdata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid)
    );

    assign evt_valid = evt_valid_q;
    assign evt_edges = evt_edges_q;
    assign evt_level = evt_level_q;
    assign evt_count = evt_count_q;
    assign busy      = busy_q;

    // State and record registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            ec_q        <= {DATA_W{1'b0}};
            evt_valid_q <= 1'b0;
            evt_edges_q <= {DATA_W{1'b0}};
            evt_level_q <= {DATA_W{1'b0}};
            evt_count_q <= {CNT_W{1'b0}};
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            ec_q        <= ec_d;
            evt_valid_q <= evt_valid_d;
            evt_edges_q <= evt_edges_d;
            evt_level_q <= evt_level_d;
            evt_count_q <= evt_count_d;
            busy_q      <= busy_d;
        end
    end

    // Next state and transfer sequencing; the clear write is launched from the latched ec.
    always_comb begin
        state_d    = state_q;
        start_s    = 1'b0;
        is_write_s = 1'b0;
        addr_s     = PIO_ADDR_DATA;
        wdata_s    = {DATA_W{1'b0}};
        case (state_q)
            INIT: begin
                if (xfer_done_s) begin
                    state_d = IDLE;
                end else if (xfer_idle_s) begin
                    start_s    = 1'b1;
                    is_write_s = 1'b1;
                    addr_s     = PIO_ADDR_MASK;
                    wdata_s    = INIT_MASK;
                end else begin
                    state_d = INIT;
                end
            end
            IDLE: begin
                if (pio_irq) begin
                    start_s = 1'b1;
                    addr_s  = PIO_ADDR_EDGE;
                    state_d = RD_EC;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_EC: begin
                if (xfer_done_s) begin
                    state_d = (xfer_rdata_s == {DATA_W{1'b0}}) ? IDLE : CLR;
                end else begin
                    state_d = RD_EC;
                end
            end
            CLR: begin
                if (xfer_done_s) begin
                    start_s = 1'b1;
                    addr_s  = PIO_ADDR_DATA;
                    state_d = RD_LVL;
                end else if (xfer_idle_s) begin
                    start_s    = 1'b1;
                    is_write_s = 1'b1;
                    addr_s     = PIO_ADDR_EDGE;
                    wdata_s    = ec_q;
                end else begin
                    state_d = CLR;
                end
            end
            RD_LVL: begin
                if (xfer_done_s) begin
                    state_d = PUSH;
                end else begin
                    state_d = RD_LVL;
                end
            end
            PUSH: begin
                if (evt_valid_q && evt_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = PUSH;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Record capture, handshake and saturating delivery count.
    always_comb begin
        ec_d        = ec_q;
        evt_valid_d = evt_valid_q;
        evt_edges_d = evt_edges_q;
        evt_level_d = evt_level_q;
        evt_count_d = evt_count_q;
        busy_d      = (state_d != IDLE);
        case (state_q)
            RD_EC: begin
                if (xfer_done_s) begin
                    ec_d = xfer_rdata_s;
                end else begin
                    ec_d = ec_q;
                end
            end
            RD_LVL: begin
                if (xfer_done_s) begin
                    evt_valid_d = 1'b1;
                    evt_edges_d = ec_q;
                    evt_level_d = xfer_rdata_s;
                end else begin
                    evt_valid_d = evt_valid_q;
                end
            end
            PUSH: begin
                if (evt_valid_q && evt_ready) begin
                    evt_valid_d = 1'b0;
                    if (evt_count_q != {CNT_W{1'b1}}) begin
                        evt_count_d = evt_count_q + CNT_W'(1);
                    end else begin
                        evt_count_d = evt_count_q;
                    end
                end else begin
                    evt_valid_d = evt_valid_q;
                end
            end
            default: begin
                evt_valid_d = evt_valid_q;
            end
        endcase
    end

endmodule

// File: tb/tb_pio_event_master.sv
// Directed bench for pio_event_master: the bench plays the PIO slave and the event
// consumer; a narrow-counter twin on the same stimulus exercises saturation.
module tb_pio_event_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic        pio_irq;
    logic        evt_ready;

    logic [1:0]  avm_address, avm_address_b;
    logic        avm_read, avm_read_b;
    logic        avm_write, avm_write_b;
    logic [31:0] avm_writedata, avm_writedata_b;
    logic        evt_valid, evt_valid_b;
    logic [1:0]  evt_edges, evt_edges_b;
    logic [1:0]  evt_level, evt_level_b;
    logic [15:0] evt_count;
    logic [1:0]  evt_count_b;
    logic        busy, busy_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    pio_event_master dut (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .pio_irq(pio_irq), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_edges(evt_edges), .evt_level(evt_level), .evt_count(evt_count), .busy(busy)
    );

    pio_event_master #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .avm_address(avm_address_b), .avm_read(avm_read_b), .avm_write(avm_write_b),
        .avm_writedata(avm_writedata_b), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
        .pio_irq(pio_irq), .evt_valid(evt_valid_b), .evt_ready(evt_ready),
        .evt_edges(evt_edges_b), .evt_level(evt_level_b), .evt_count(evt_count_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Slave side of one read: optional stall, then data one cycle after acceptance.
    task automatic serve_read(input string tag, input logic [1:0] addr,
                              input logic [31:0] data, input int nwait);
        for (int i = 0; i < 64 && avm_read !== 1'b1; i++) @(negedge clk);
        chk({tag, "_read"}, 32'(avm_read), 32'd1);
        chk({tag, "_addr"}, 32'(avm_address), 32'(addr));
        chk({tag, "_nowrite"}, 32'(avm_write), 32'd0);
        if (nwait > 0) avm_waitrequest = 1'b1;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk({tag, "_stall_read"}, 32'(avm_read), 32'd1);
            chk({tag, "_stall_addr"}, 32'(avm_address), 32'(addr));
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk({tag, "_read_drop"}, 32'(avm_read), 32'd0);
        avm_readdatavalid = 1'b1;
        avm_readdata      = data;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hFFFF_FFFF;
    endtask

    task automatic serve_write(input string tag, input logic [1:0] addr,
                               input logic [31:0] data, input int nwait);
        for (int i = 0; i < 64 && avm_write !== 1'b1; i++) @(negedge clk);
        chk({tag, "_write"}, 32'(avm_write), 32'd1);
        chk({tag, "_addr"}, 32'(avm_address), 32'(addr));
        chk({tag, "_data"}, avm_writedata, data);
        chk({tag, "_noread"}, 32'(avm_read), 32'd0);
        if (nwait > 0) avm_waitrequest = 1'b1;
        for (int i = 0; i < nwait; i++) begin
            @(negedge clk);
            chk({tag, "_stall_write"}, 32'(avm_write), 32'd1);
            chk({tag, "_stall_addr"}, 32'(avm_address), 32'(addr));
            chk({tag, "_stall_data"}, avm_writedata, data);
        end
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk({tag, "_write_drop"}, 32'(avm_write), 32'd0);
    endtask

    task automatic expect_event(input string tag, input logic [1:0] edges,
                                input logic [1:0] level, input int hold);
        for (int i = 0; i < 64 && evt_valid !== 1'b1; i++) @(negedge clk);
        chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
        chk({tag, "_edges"}, 32'(evt_edges), 32'(edges));
        chk({tag, "_level"}, 32'(evt_level), 32'(level));
        evt_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_bp_valid"}, 32'(evt_valid), 32'd1);
            chk({tag, "_bp_edges"}, 32'(evt_edges), 32'(edges));
            chk({tag, "_bp_level"}, 32'(evt_level), 32'(level));
        end
        evt_ready = 1'b1;
        @(negedge clk);
        evt_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        reset_n           = 1'b0;
        avm_readdata      = 32'd0;
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        pio_irq           = 1'b0;
        evt_ready         = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_address", 32'(avm_address), 32'd0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_writedata", avm_writedata, 32'd0);
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_edges", 32'(evt_edges), 32'd0);
        chk("rst_level", 32'(evt_level), 32'd0);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Init: one mask write of 0x3, then idle and quiet
        reset_n = 1'b1;
        serve_write("init", 2'd2, 32'h0000_0003, 0);
        chk("init_busy", 32'(busy), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("init_quiet_wr", 32'(avm_write), 32'd0);
            chk("init_quiet_rd", 32'(avm_read), 32'd0);
        end

        // Single event, zero wait states: latency 7 cycles irq-to-valid
        pio_irq = 1'b1;
        t0 = cyc;
        serve_read("s_ec", 2'd3, 32'h0000_0001, 0);
        serve_write("s_clr", 2'd3, 32'h0000_0001, 0);
        pio_irq = 1'b0;
        serve_read("s_lvl", 2'd0, 32'h0000_0001, 0);
        chk("s_latency", 32'(cyc - t0), 32'd7);
        expect_event("s_evt", 2'b01, 2'b01, 0);
        chk("s_count", 32'(evt_count), 32'd1);
        chk("s_busy", 32'(busy), 32'd0);

        // Spurious irq: ec 0, no clear, no record; evt_ready outside PUSH is ignored
        evt_ready = 1'b1;
        pio_irq   = 1'b1;
        serve_read("sp_ec", 2'd3, 32'h0000_0000, 0);
        pio_irq = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("sp_no_write", 32'(avm_write), 32'd0);
            chk("sp_no_valid", 32'(evt_valid), 32'd0);
        end
        evt_ready = 1'b0;
        chk("sp_busy", 32'(busy), 32'd0);
        chk("sp_count", 32'(evt_count), 32'd1);

        // Stalls and backpressure; upper readdata bits are ignored
        pio_irq = 1'b1;
        serve_read("st_ec", 2'd3, 32'hFFFF_FFFE, 4);
        serve_write("st_clr", 2'd3, 32'h0000_0002, 4);
        pio_irq = 1'b0;
        serve_read("st_lvl", 2'd0, 32'h0000_0007, 4);
        expect_event("st_evt", 2'b10, 2'b11, 5);
        chk("st_count", 32'(evt_count), 32'd2);
        chk("st_count_sat", 32'(evt_count_b), 32'd2);
        repeat (3) begin
            @(negedge clk);
            chk("st_single_record", 32'(evt_valid), 32'd0);
        end

        // Back-to-back: irq stays high, second edge serviced straight from IDLE
        pio_irq = 1'b1;
        serve_read("bb1_ec", 2'd3, 32'h0000_0001, 0);
        serve_write("bb1_clr", 2'd3, 32'h0000_0001, 0);
        serve_read("bb1_lvl", 2'd0, 32'h0000_0001, 0);
        expect_event("bb1_evt", 2'b01, 2'b01, 0);
        chk("bb1_count", 32'(evt_count), 32'd3);
        chk("bb1_count_sat", 32'(evt_count_b), 32'd3);
        serve_read("bb2_ec", 2'd3, 32'h0000_0002, 0);
        serve_write("bb2_clr", 2'd3, 32'h0000_0002, 0);
        pio_irq = 1'b0;
        serve_read("bb2_lvl", 2'd0, 32'h0000_0002, 0);
        expect_event("bb2_evt", 2'b10, 2'b10, 0);
        chk("bb2_count", 32'(evt_count), 32'd4);
        chk("bb2_count_sat", 32'(evt_count_b), 32'd3);

        // Reset while the level read is outstanding; late response must be dropped
        pio_irq = 1'b1;
        serve_read("rr_ec", 2'd3, 32'h0000_0003, 0);
        serve_write("rr_clr", 2'd3, 32'h0000_0003, 0);
        pio_irq = 1'b0;
        for (int i = 0; i < 64 && avm_read !== 1'b1; i++) @(negedge clk);
        chk("rr_lvl_read", 32'(avm_read), 32'd1);
        chk("rr_lvl_addr", 32'(avm_address), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rr_rst_read", 32'(avm_read), 32'd0);
        chk("rr_rst_write", 32'(avm_write), 32'd0);
        chk("rr_rst_busy", 32'(busy), 32'd1);
        chk("rr_rst_count", 32'(evt_count), 32'd0);
        chk("rr_rst_edges", 32'(evt_edges), 32'd0);
        @(negedge clk);
        reset_n           = 1'b1;
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'h0000_0003;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hFFFF_FFFF;
        serve_write("rr_remask", 2'd2, 32'h0000_0003, 0);
        repeat (4) begin
            @(negedge clk);
            chk("rr_no_valid", 32'(evt_valid), 32'd0);
            chk("rr_no_read", 32'(avm_read), 32'd0);
        end
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_count", 32'(evt_count), 32'd0);
        chk("rr_level", 32'(evt_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
